// File: rtl/pck_eject_buf.sv
// pck_eject_buf: NoC ejection buffer. Per-VC FWFT FIFOs feed a packet-atomic,
// round-robin arbiter that presents flits on a valid/ready stream. One
// registered credit is returned per popped flit.
// Optional feature macro: PCK_EJECT_SIZE_EN builds the out_pck_size counter;
// without it out_pck_size is tied to 0.

module pck_eject_fifo #(
    parameter int B = 4,
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = (B > 1) ? $clog2(B) : 1;
    localparam int CW = $clog2(B + 1);

    logic [W-1:0]  mem [B];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(B - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(B));
    // Head of queue is always visible; no write-to-read bypass.
    assign dout  = mem[rp];

    // Storage array, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr && !full) mem[wp] <= din;
    end

    // Pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr && !full) wp <= nxt(wp);
            if (rd && !empty) rp <= nxt(rp);
            case ({wr && !full, rd && !empty})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module pck_eject_buf #(
    parameter int V        = 4,
    parameter int B        = 4,
    parameter int Fpay     = 32,
    parameter int PCK_SIZw = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flit_wr,
    input  logic [V-1:0]                 flit_vc,
    input  logic                         flit_hdr,
    input  logic                         flit_tail,
    input  logic [Fpay-1:0]              flit_payload,
    output logic [V-1:0]                 credit_out,
    output logic [V*$clog2(B+1)-1:0]     credit_init_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [V-1:0]                 out_vc,
    output logic                         out_hdr,
    output logic                         out_tail,
    output logic [Fpay-1:0]              out_payload,
    output logic [PCK_SIZw-1:0]          out_pck_size,
    output logic                         overflow_err,
    output logic                         protocol_err
);
    localparam int CW = $clog2(B + 1);
    localparam int GW = (V > 1) ? $clog2(V) : 1;
    localparam int FW = Fpay + 2;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      sel_q, sel_d, rr_q, rr_d, gnt, srch_vc, cand;
    logic               hold_q, hold_d;
    logic [V-1:0]       empty, full, wr_en, rd_en, credit_q;
    logic [V-1:0][FW-1:0] head;
    logic [FW-1:0]      hsel;
    logic               vc_ok, pop, bad_hdr;

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int off);
        int s;
        s = int'(a) + off;
        if (s >= V) s = s - V;
        return GW'(s);
    endfunction

    assign vc_ok = $onehot(flit_vc);

    genvar v;
    generate
        for (v = 0; v < V; v++) begin : g_vc
            assign wr_en[v] = flit_wr && vc_ok && flit_vc[v] && !full[v];
            assign rd_en[v] = pop && (gnt == GW'(v));
            assign credit_init_val[v*CW +: CW] = CW'(B);
            pck_eject_fifo #(.B(B), .W(FW)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .wr    (wr_en[v]),
                .rd    (rd_en[v]),
                .din   ({flit_hdr, flit_tail, flit_payload}),
                .dout  (head[v]),
                .empty (empty[v]),
                .full  (full[v])
            );
        end
    endgenerate

    // Round-robin search: lowest offset from rr wins (loop runs high to low).
    always_comb begin
        srch_vc = rr_q;
        cand    = rr_q;
        for (int i = V - 1; i >= 0; i--) begin
            cand = wrap_add(rr_q, i);
            if (!empty[cand]) srch_vc = cand;
        end
    end

    // Source select: locked VC, or a stalled IDLE grant held for output stability.
    always_comb begin
        if (state_q == LOCKED || hold_q) gnt = sel_q;
        else                             gnt = srch_vc;
    end

    assign hsel        = head[gnt];
    assign out_valid   = !empty[gnt];
    assign out_hdr     = out_valid & hsel[FW-1];
    assign out_tail    = out_valid & hsel[FW-2];
    assign out_payload = out_valid ? hsel[Fpay-1:0] : '0;
    assign out_vc      = out_valid ? (V'(1) << gnt) : '0;
    assign pop         = out_valid & out_ready;
    assign credit_out  = credit_q;
    assign bad_hdr     = (state_q == IDLE) && out_valid && !hsel[FW-1];

    // Arbiter next state: first pop in IDLE takes the lock unless it is a tail.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (out_valid) begin
                    sel_d  = gnt;
                    hold_d = !out_ready;
                    if (out_ready) begin
                        rr_d = wrap_add(gnt, 1);
                        if (!out_tail) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (pop && out_tail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter registers, credit return and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            hold_q       <= 1'b0;
            rr_q         <= '0;
            credit_q     <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            credit_q <= pop ? out_vc : '0;
            if (flit_wr && vc_ok && |(flit_vc & full)) overflow_err <= 1'b1;
            if ((flit_wr && !vc_ok) || bad_hdr)        protocol_err <= 1'b1;
        end
    end

`ifdef PCK_EJECT_SIZE_EN
    logic [PCK_SIZw-1:0] size_q, size_nxt;
    assign size_nxt     = (state_q == IDLE) ? PCK_SIZw'(1) :
                          ((&size_q) ? size_q : size_q + 1'b1);
    assign out_pck_size = out_valid ? size_nxt : '0;

    // Count of popped flits in the current packet, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   size_q <= '0;
        else if (pop) size_q <= size_nxt;
    end
`else
    assign out_pck_size = '0;
`endif
endmodule

// File: doc/pck_eject_buf.md
# pck_eject_buf

Endpoint-side ejection buffer that terminates a NoC output channel. It accepts flits from the router into per-VC FIFOs and returns one credit per consumed flit, the receiving end of the injector's credit counter. It delivers flits to the local consumer as a packet-atomic, round-robin-arbitrated flit stream with valid/ready handshaking. It sits between a router local port and an endpoint core or traffic sink.

## Interface
- V, 4, number of virtual channels
- B, 4, per-VC FIFO depth in flits; also the advertised credit init value
- Fpay, 32, flit payload width
- PCK_SIZw, 8, packet size counter width
- clk, input, 1, clock; all state on rising edge
- reset, input, 1, asynchronous, active-low reset
- flit_wr, input, 1, flit valid from router
- flit_vc, input, V, one-hot VC of incoming flit
- flit_hdr, input, 1, header flag
- flit_tail, input, 1, tail flag
- flit_payload, input, Fpay, flit payload
- credit_out, output, V, one-hot credit return to router
- credit_init_val, output, V*log2(B+1), constant B per VC
- out_valid, output, 1, output flit valid
- out_ready, input, 1, consumer accepts flit
- out_vc, output, V, one-hot VC of output flit
- out_hdr / out_tail, output, 1 each, flags of output flit
- out_payload, output, Fpay, payload of output flit
- out_pck_size, output, PCK_SIZw, flits in packet; meaningful when out_valid & out_tail
- overflow_err, output, 1, sticky: write into full VC
- protocol_err, output, 1, sticky: non-header flit at arbitration point

## Operation
- Per-VC FIFO stores {hdr, tail, payload}. A write goes to the VC selected by flit_vc when flit_wr=1. If flit_wr=1 with more than one bit set or all bits clear, nothing is written and protocol_err is set.
- Write to a full VC is dropped and sets overflow_err. This holds even if the same VC pops in the same cycle.
- Occupancy counter width is log2(B+1) and reaches exactly B. Read and write pointers wrap modulo B.
- Arbiter states:
  - IDLE: grant the first non-empty VC, searching round-robin from pointer rr. Pointer is 0 after reset.
  - LOCKED: the granted VC is the only source.
- Entering LOCKED and advancing rr:
  - In IDLE, the granted head flit must have hdr=1.
  - If hdr=0, that flit is presented anyway and protocol_err is set. The lock is then taken normally.
  - Popping a header with tail=0 moves the arbiter to LOCKED.
  - rr advances to (granted+1) mod V on every header pop.
- In LOCKED, out_valid = that VC non-empty. Popping a tail returns to IDLE. A header+tail single-flit packet never enters LOCKED.
- Pop = out_valid & out_ready. Each pop sets credit_out[vc] for exactly one cycle.
- out_pck_size counts popped flits of the current packet:
  - Reset to 1 on header pop.
  - Incremented on each later pop.
  - Saturates at 2^PCK_SIZw-1.
  - The presented value on the tail flit includes the tail.

## Timing
- Reset values:
  - out_valid=0, credit_out=0, both error flags 0, out_pck_size=0.
  - Arbiter IDLE, rr=0, all FIFOs empty.
  - Other out_* fields are 0 while out_valid=0.
- FIFO is first-word-fall-through with no write-to-read bypass. A flit written in cycle n can raise out_valid in cycle n+1 at the earliest.
- out_* outputs are combinational from FIFO head and arbiter state. They hold stable while out_valid=1 and out_ready=0.
- credit_out is registered: a pop in cycle n gives credit_out[vc]=1 in cycle n+1. Back-to-back pops give back-to-back credits.
- Simultaneous write and pop on the same non-full VC leaves occupancy unchanged.
- Sustained throughput is 1 flit/cycle.
- Asserting reset mid-packet immediately clears all FIFOs, the lock, and pending credits.

## Configuration
- PCK_EJECT_SIZE_EN
  - Defined: the out_pck_size counter is implemented as described.
  - Undefined: the counter is not built and out_pck_size is tied to 0.
- All other behaviour is identical in both cases.

## Test plan
- Single-flit packet (hdr=tail=1, VC0, payload 0xA5) with out_ready=1:
  - out_valid next cycle with out_pck_size=1.
  - credit_out=4'b0001 one cycle after the pop; arbiter stays IDLE.
- 3-flit packet on VC1 interleaved flit-by-flit with a 2-flit packet on VC2:
  - Output is all VC1 flits contiguously, then VC2.
  - out_pck_size=3 then 2.
  - 5 credits returned, one per pop.
- Fill VC3 with B=4 flits with out_ready=0, then write a 5th:
  - overflow_err=1 and occupancy stays 4.
  - Draining yields exactly 4 flits and 4 credits.
- Header flits waiting on all 4 VCs with out_ready=1:
  - Grant order is VC0,1,2,3.
  - Refill VC0 and VC2: next order is VC0 then VC2.
- Body flit (hdr=0) first into an empty VC while IDLE: protocol_err=1 and the flit is still delivered.
- Reset asserted mid-packet while LOCKED:
  - out_valid=0 and credit_out=0 immediately.
  - After release, a new header on any VC is granted normally.
